// File: rtl/out_uart_tx.sv
// out_uart_tx: CPU output-register byte FIFO feeding an 8N1 UART transmitter.
// The line idles high. Each frame is sent LSB first: start bit, 8 data bits, stop bit.
// Optional macro OUT_UART_TX_HEX_EN: each byte is sent as two uppercase ASCII hex
// characters followed by a line feed (three back-to-back frames, one FIFO pop).
// When the macro is undefined, each byte is sent as a single raw frame.
module out_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BIT_TC  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Transmitter state
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bit_tc;

    // FIFO state
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             fifo_empty, fifo_full;
    logic             push, pop, drop;
    logic [7:0]       head;

    // Character sequencing: what to load on a pop, and whether the current
    // byte still has characters to send after the frame in flight.
    logic [7:0] first_char;
    logic       more_chars;
    logic [7:0] next_char;

`ifdef OUT_UART_TX_HEX_EN
    logic [7:0] byte_q, byte_d;  // byte being rendered as hex
    logic [1:0] hex_q, hex_d;    // characters still to send after the current frame

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign first_char = hex_char(head[7:4]);
    assign more_chars = (hex_q != 2'd0);
    assign next_char  = (hex_q == 2'd2) ? hex_char(byte_q[3:0]) : 8'h0A;
`else
    assign first_char = head;
    assign more_chars = 1'b0;
    assign next_char  = 8'h00;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign head       = mem_q[rd_ptr_q];
    assign bit_tc     = (timer_q == BIT_TC);

    // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
    assign push = i_valid && (!fifo_full || pop);
    assign drop = i_valid && fifo_full && !pop;

    // Next-state, pop decision and line value for the transmitter FSM.
    always_comb begin
        // NOTE: every signal this block drives gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
        state_d = state_q;
        timer_d = bit_tc ? 16'd0 : timer_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_d = 16'd0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_tc) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_tc) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_tc) begin
                    if (more_chars) begin
                        state_d = START;
                        shift_d = next_char;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The popped byte is captured in the shift register, so later pushes cannot touch a frame in flight.
        if (pop) begin
            shift_d = first_char;
        end
    end

    // Transmitter registers; the line output is registered from the current state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            timer_q <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef OUT_UART_TX_HEX_EN
    // Hex character sequencing: remember the popped byte and count the remaining characters.
    always_comb begin
        byte_d = byte_q;
        hex_d  = hex_q;
        if (pop) begin
            byte_d = head;
            hex_d  = 2'd2;
        end else if (state_q == STOP && bit_tc && more_chars) begin
            hex_d = hex_q - 2'd1;
        end
    end

    // Hex sequencing registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_q <= 8'h00;
            hex_q  <= 2'd0;
        end else begin
            byte_q <= byte_d;
            hex_q  <= hex_d;
        end
    end
`endif

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array has no reset; the pointers and count alone define which entries are valid.
        if (push && !i_reset) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_tx       = tx_q;
    assign o_busy     = !fifo_empty || (state_q != IDLE);
    assign o_full     = fifo_full;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: directed bench for out_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A frame-level model (queues and a frame offset counter) predicts every output
// on every cycle. A line receiver decodes o_tx independently, and directed
// checks pin literal values such as latency, bit pattern and frame spacing.
`timescale 1ns/1ps
module tb_out_uart_tx;

    localparam int C     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * C;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       tx, busy, full, ovf;

    out_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_data    (data),
        .i_valid   (valid),
        .o_tx      (tx),
        .o_busy    (busy),
        .o_full    (full),
        .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: a byte queue and a list of characters still to send
    // for the current byte. m_t is the offset within the 10-bit frame. The
    // line output lags the frame position by one cycle.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    logic [7:0] m_fq[$];
    logic [7:0] m_cur;
    bit         m_act;
    int         m_t;
    bit         m_ovf;
    bit         m_tx;
    bit         m_ok;
    string      hexdig = "0123456789ABCDEF";

    function automatic logic frame_bit(input logic [7:0] c, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return c[i-1];
    endfunction

    always @(posedge clk) begin
        bit         start;
        logic [7:0] nxt;
        logic [7:0] b;
        if (rst) begin
            m_q.delete();
            m_fq.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_ovf = 1'b0;
            m_tx  = 1'b1;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            m_tx  = m_act ? frame_bit(m_cur, m_t / C) : 1'b1;
            start = 1'b0;
            nxt   = 8'h00;
            if (!m_act || m_t == FRAME - 1) begin
                if (m_fq.size() == 0 && m_q.size() > 0) begin
                    b = m_q.pop_front();
`ifdef OUT_UART_TX_HEX_EN
                    m_fq.push_back(hexdig[b[7:4]]);
                    m_fq.push_back(hexdig[b[3:0]]);
                    m_fq.push_back(8'h0A);
`else
                    m_fq.push_back(b);
`endif
                end
                if (m_fq.size() > 0) begin
                    nxt   = m_fq.pop_front();
                    start = 1'b1;
                end
            end
            if (valid) begin
                if (m_q.size() < D) m_q.push_back(data);
                else m_ovf = 1'b1;
            end
            if (start) begin
                m_act = 1'b1;
                m_t   = 0;
                m_cur = nxt;
            end else if (m_act) begin
                if (m_t == FRAME - 1) begin
                    m_act = 1'b0;
                    m_t   = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            check("model_tx",   tx,   m_tx);
            check("model_busy", busy, (m_act || m_q.size() > 0));
            check("model_full", full, (m_q.size() == D));
            check("model_ovf",  ovf,  m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Independent line receiver: detect the start bit, sample mid-bit.
    // ------------------------------------------------------------------
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_bad = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !rst) begin
                rx_t.push_back(cyc);
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx;
                end
                repeat (C) @(negedge clk);
                if (tx !== 1'b1) rx_bad++;
                rx_q.push_back(b);
            end
        end
    end

    logic [7:0] exp_q[$];

    task automatic rx_clear();
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        rx_bad = 0;
    endtask

    // Compare the received bytes against exp_q; all frames must be back-to-back.
    task automatic check_rx(input string name);
        check({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
        for (int i = 1; i < rx_t.size(); i++)
            check($sformatf("%s_gap%0d", name, i), rx_t[i] - rx_t[i-1], FRAME);
        check({name, "_stop"}, rx_bad, 0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] b);
        valid = 1'b1;
        data  = b;
        tick();
        valid = 1'b0;
    endtask

    // Tick until o_busy falls; e counts edges since the first strobe edge.
    task automatic wait_idle(input string name, input int limit, inout int e);
        while (busy === 1'b1 && e < limit) begin
            tick();
            e++;
        end
        check({name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int         e;
        logic [9:0] line;

        rst = 1'b1;
        repeat (3) tick();
        check("reset_tx",   tx,   1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_full", full, 1'b0);
        check("reset_ovf",  ovf,  1'b0);
        rst = 1'b0;
        repeat (2) tick();

`ifndef OUT_UART_TX_HEX_EN
        // Single byte 0xA5: latency, bit pattern, busy duration.
        rx_clear();
        strobe(8'hA5);
        tick();
        check("a5_lat_edge1", tx, 1'b1);
        tick();
        check("a5_lat_edge2", tx, 1'b0);
        line[0] = tx;
        for (int k = 1; k < 10; k++) begin
            repeat (C) tick();
            line[k] = tx;
        end
        e = 2 + 9 * C;
        check("a5_line", line, 10'b1101001010);
        wait_idle("a5", 200, e);
        check("a5_busy_fall", e, 41);
        repeat (4) tick();
        exp_q.push_back(8'hA5);
        check_rx("a5");

        // Three consecutive strobes: contiguous frames, 120 cycles total.
        rx_clear();
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        e = 2;
        check("burst_ovf", ovf, 1'b0);
        wait_idle("burst", 400, e);
        check("burst_busy_fall", e, 121);
        repeat (4) tick();
        exp_q = '{8'h01, 8'h02, 8'h03};
        check_rx("burst");

        // Six strobes: one popped, four queued, one dropped.
        rx_clear();
        strobe(8'h11);
        strobe(8'h22);
        strobe(8'h33);
        strobe(8'h44);
        strobe(8'h55);
        strobe(8'h66);
        check("ovfl_full", full, 1'b1);
        check("ovfl_sticky", ovf, 1'b1);
        e = 5;
        wait_idle("ovfl", 600, e);
        check("ovfl_ovf_holds", ovf, 1'b1);
        repeat (4) tick();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_rx("ovfl");

        // Reset 13 cycles into a frame aborts it and clears the overflow flag.
        rx_clear();
        strobe(8'h5A);
        repeat (13) tick();
        rst = 1'b1;
        tick();
        check("abort_tx",   tx,   1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ovf",  ovf,  1'b0);
        check("abort_full", full, 1'b0);
        rst = 1'b0;
        repeat (60) tick();
        rx_clear();
        strobe(8'h3C);
        e = 0;
        wait_idle("after_abort", 200, e);
        check("after_abort_busy_fall", e, 41);
        repeat (4) tick();
        exp_q.push_back(8'h3C);
        check_rx("after_abort");

        // Push on the same edge as a pop while the FIFO is full.
        rx_clear();
        strobe(8'hC1);
        strobe(8'hC2);
        strobe(8'hC3);
        strobe(8'hC4);
        strobe(8'hC5);
        check("pp_full_before", full, 1'b1);
        check("pp_ovf_before",  ovf,  1'b0);
        repeat (36) tick();
        check("pp_full_edge40", full, 1'b1);
        strobe(8'hC6);
        check("pp_full_after", full, 1'b1);
        check("pp_ovf_after",  ovf,  1'b0);
        e = 41;
        wait_idle("pp", 800, e);
        check("pp_busy_fall", e, 241);
        repeat (4) tick();
        exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        check_rx("pp");
`else
        // Hex mode: 0x3C is sent as '3', 'C', LF from a single pop.
        rx_clear();
        strobe(8'h3C);
        tick();
        check("hex_lat_edge1", tx, 1'b1);
        tick();
        check("hex_lat_edge2", tx, 1'b0);
        e = 2;
        wait_idle("hex", 400, e);
        check("hex_busy_fall", e, 121);
        repeat (4) tick();
        exp_q = '{8'h33, 8'h43, 8'h0A};
        check_rx("hex");

        // Two bytes back-to-back: six contiguous frames.
        rx_clear();
        strobe(8'hA0);
        strobe(8'h9F);
        e = 1;
        wait_idle("hex2", 600, e);
        check("hex2_busy_fall", e, 241);
        repeat (4) tick();
        exp_q = '{8'h41, 8'h30, 8'h0A, 8'h39, 8'h46, 8'h0A};
        check_rx("hex2");
`endif

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
